div_issue_ctrl: RTL and testbench

Valid/ready front-end for the fixed-latency signed pipelined divider, which has no stall or valid signals. The block accepts tagged operand pairs, drives the divider inputs, and tracks each operation through a valid/tag shadow pipeline matched to the divider latency. It resolves divide-by-zero and overflow at issue and collects results in order in a result FIFO. Credit control keeps that FIFO from overflowing when the consumer stalls.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_issue_ctrl_chk.sv | 21 ++
 rtl/div_result_fifo.sv | 81 ++++++++
 rtl/div_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/writeback front-end.
package div_pkg;

  // Default divider latency: 5 pipeline stages plus the output register.
  localparam int DIV_LATENCY_DEF = 6;

  // Tag width carried through the shadow pipeline. div_issue_ctrl casts its
  // TAG_W into this field, so TAG_W must not exceed this value.
  localparam int TAG_W_DEF = 4;

  // Exception flags resolved at issue time.
  typedef struct packed {
    logic ovf;
    logic dz;
  } div_flags_t;

  // One slot of the shadow pipeline that tracks an operation in the divider.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    div_flags_t           flags;
  } pipe_entry_t;

  // Most negative two's-complement value of the given width (width <= 64).
  function automatic logic [63:0] int_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_chk.sv
// Invariant checks for div_issue_ctrl: credit control must keep the result
// FIFO from ever being pushed while full, and the FIFO can never hold more
// entries than there are outstanding operations.
module div_issue_ctrl_chk #(
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             push,
  input logic             fifo_full,
  input logic [CNT_W-1:0] fifo_count,
  input logic [CNT_W-1:0] outstanding
);

  no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full));

  fifo_within_credit: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= outstanding);

endmodule

// File: rtl/div_result_fifo.sv
// Synchronous show-ahead FIFO holding divider results until consumed.
// Output data reads as zero while empty so stale entries never leak out.
module div_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // Writes into a full FIFO and reads from an empty one are dropped.
  assign wr_en_s = push && (count_q != DEPTH_C);
  assign rd_en_s = pop && (count_q != '0);

  // Pointer wrap and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because output is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/div_issue_ctrl.sv
// Valid/ready front-end for a fixed-latency signed pipelined divider.
// Requests are registered onto the divider inputs, tracked by a shadow
// valid/tag pipeline matched to the divider latency, and collected in order
// in a result FIFO. Credits (outstanding count) bound in-flight work to the
// FIFO depth so results can always drain even while the consumer stalls.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DATA_LEN    = 32,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_a,
  input  logic [DATA_LEN-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic [DATA_LEN-1:0] div_a,
  output logic [DATA_LEN-1:0] div_b,
  input  logic [DATA_LEN-1:0] div_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_quot,
  output logic [TAG_W-1:0]    out_tag,
  output logic [1:0]          out_flags
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = DATA_LEN + TAG_W + 2;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [DATA_LEN-1:0] INT_MIN = DATA_LEN'(int_min(DATA_LEN));

  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_LEN-1:0] div_a_q, div_a_d;
  logic [DATA_LEN-1:0] div_b_q, div_b_d;
  pipe_entry_t         pipe_q [0:DIV_LATENCY];
  pipe_entry_t         pipe_d [0:DIV_LATENCY];

  logic                accept_s;
  logic                pop_s;
  logic                push_s;
  div_flags_t          flags_in_s;
  logic [DATA_LEN-1:0] wb_quot_s;
  logic [ENTRY_W-1:0]  fifo_wdata_s;
  logic [ENTRY_W-1:0]  fifo_rdata_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;

  assign accept_s = in_valid && in_ready_q;
  assign pop_s    = !fifo_empty_s && out_ready;

  // Exceptions are decided on the raw operands, before divisor substitution.
  assign flags_in_s.dz  = (in_b == '0);
  assign flags_in_s.ovf = (in_a == INT_MIN) && (in_b == '1);

  // Credit counter; in_ready is registered from the next count so it never
  // depends combinationally on in_valid.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept_s, pop_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1'b1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1'b1);
      default: outstanding_d = outstanding_q;
    endcase
    in_ready_d = (outstanding_d < DEPTH_C);
  end

  // Issue stage and unconditional shift of the shadow pipeline.
  always_comb begin
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    pipe_d[0] = '0;
    if (accept_s) begin
      div_a_d         = in_a;
      // A zero divisor is replaced by 1 so the divider never sees x/0.
      div_b_d         = flags_in_s.dz ? DATA_LEN'(1'b1) : in_b;
      pipe_d[0].valid = 1'b1;
      pipe_d[0].tag   = TAG_W_DEF'(in_tag);
      pipe_d[0].flags = flags_in_s;
    end else begin
      div_a_d   = div_a_q;
      div_b_d   = div_b_q;
      pipe_d[0] = '0;
    end
    for (int i = 1; i <= DIV_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Writeback quotient: exceptions override whatever the divider produced.
  always_comb begin
    if (pipe_q[DIV_LATENCY].flags.dz) begin
      wb_quot_s = '1;
    end else if (pipe_q[DIV_LATENCY].flags.ovf) begin
      wb_quot_s = INT_MIN;
    end else begin
      wb_quot_s = div_result;
    end
  end

  // Control, operand and shadow pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      in_ready_q    <= 1'b1;
      div_a_q       <= '0;
      div_b_q       <= '0;
      for (int i = 0; i <= DIV_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      in_ready_q    <= in_ready_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      pipe_q        <= pipe_d;
    end
  end

  assign push_s       = pipe_q[DIV_LATENCY].valid;
  assign fifo_wdata_s = {wb_quot_s, TAG_W'(pipe_q[DIV_LATENCY].tag),
                         pipe_q[DIV_LATENCY].flags};

  div_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (fifo_wdata_s),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  div_issue_ctrl_chk #(
    .CNT_W (CNT_W)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .push        (push_s),
    .fifo_full   (fifo_full_s),
    .fifo_count  (fifo_count_s),
    .outstanding (outstanding_q)
  );

  assign in_ready  = in_ready_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign out_valid = !fifo_empty_s;
  assign out_quot  = fifo_rdata_s[ENTRY_W-1 -: DATA_LEN];
  assign out_tag   = fifo_rdata_s[2 +: TAG_W];
  assign out_flags = fifo_rdata_s[1:0];

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl with a behavioural
// 6-cycle signed divider attached to div_a/div_b/div_result.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quot;
  logic [3:0]  out_tag;
  logic [1:0]  out_flags;

  int errors = 0;
  int checks = 0;

  logic [31:0] div_model_q [0:5];

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_quot   (out_quot),
    .out_tag    (out_tag),
    .out_flags  (out_flags)
  );

  // Environment divider: truncating signed division, guarded against x/0 and
  // the INT_MIN/-1 host overflow.
  function automatic logic [31:0] env_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (b == 32'hFFFF_FFFF) return 32'd0 - a;
    return $signed(a) / $signed(b);
  endfunction

  // Divider stand-in: samples inputs each edge, result 6 edges after issue.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) div_model_q[i] <= 32'd0;
    end else begin
      div_model_q[0] <= env_div(div_a, div_b);
      for (int i = 1; i < 6; i++) div_model_q[i] <= div_model_q[i-1];
    end
  end
  assign div_result = div_model_q[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_tag = 4'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (div_a !== 32'd0) begin errors++; $display("FAIL reset_div_a: got %h expected 0", div_a); end
    checks++; if (div_b !== 32'd0) begin errors++; $display("FAIL reset_div_b: got %h expected 0", div_b); end
    checks++; if (out_quot !== 32'd0) begin errors++; $display("FAIL reset_out_quot: got %h expected 0", out_quot); end
    checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    checks++; if (out_flags !== 2'b00) begin errors++; $display("FAIL reset_out_flags: got %b expected 00", out_flags); end
  endtask

  // Issue one request into an idle block and follow it to the output.
  task automatic run_single(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, input logic [31:0] exp_q,
                            input logic [1:0] exp_f, input logic [31:0] exp_db);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", name, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (div_a !== a) begin errors++; $display("FAIL %s_div_a: got %h expected %h", name, div_a, a); end
    checks++; if (div_b !== exp_db) begin errors++; $display("FAIL %s_div_b: got %h expected %h", name, div_b, exp_db); end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL %s_latency: got %0d expected 7", name, lat); end
    checks++; if (out_quot !== exp_q) begin errors++; $display("FAIL %s_quot: got %h expected %h", name, out_quot, exp_q); end
    checks++; if (out_tag !== tag) begin errors++; $display("FAIL %s_tag: got %h expected %h", name, out_tag, tag); end
    checks++; if (out_flags !== exp_f) begin errors++; $display("FAIL %s_flags: got %b expected %b", name, out_flags, exp_f); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained: got %b expected 0", name, out_valid); end
  endtask

  task automatic test_basic();
    run_single("div_100_7", 32'd100, 32'd7, 4'd3, 32'd14, 2'b00, 32'd7);
  endtask

  task automatic test_signs();
    run_single("div_m7_2", 32'hFFFF_FFF9, 32'd2, 4'd5, 32'hFFFF_FFFD, 2'b00, 32'd2);
    run_single("div_7_m2", 32'd7, 32'hFFFF_FFFE, 4'd6, 32'hFFFF_FFFD, 2'b00, 32'hFFFF_FFFE);
  endtask

  task automatic test_div_by_zero();
    run_single("div_5_0", 32'd5, 32'd0, 4'd7, 32'hFFFF_FFFF, 2'b01, 32'd1);
  endtask

  task automatic test_overflow();
    run_single("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'h8000_0000, 2'b10, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [20];
    logic [31:0] vb [20];
    logic [31:0] vq [20];
    int n_tx, n_rx, cyc;
    logic tx_now, rx_now;
    // Operands built as a = q*|b| + r (r < |b|) so the truncated quotient is known.
    for (int i = 0; i < 20; i++) begin
      int q, bm, r, sa, sb;
      q  = i * 3 + 1;
      bm = (i % 5) + 1;
      r  = i % bm;
      sa = (i % 2 == 1) ? -1 : 1;
      sb = (i % 3 == 0) ? -1 : 1;
      va[i] = sa * (q * bm + r);
      vb[i] = sb * bm;
      vq[i] = sa * sb * q;
    end
    n_tx = 0; n_rx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1; in_a = va[n_tx]; in_b = vb[n_tx]; in_tag = 4'(n_tx);
      tx_now = in_ready;
      tick();
      if (tx_now) n_tx++;
    end
    checks++; if (n_tx != 8) begin errors++; $display("FAIL b2b_credit_accepts: got %0d expected 8", n_tx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_low: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd0) begin errors++; $display("FAIL b2b_head_held: got valid=%b tag=%h expected valid=1 tag=0", out_valid, out_tag); end
    out_ready = 1'b1;
    cyc = 0;
    while (n_rx < 20 && cyc < 300) begin
      if (n_tx < 20) begin
        in_valid = 1'b1; in_a = va[n_tx]; in_b = vb[n_tx]; in_tag = 4'(n_tx);
      end else begin
        in_valid = 1'b0;
      end
      tx_now = in_valid && in_ready;
      rx_now = out_valid && out_ready;
      if (rx_now) begin
        checks++;
        if (out_quot !== vq[n_rx] || out_tag !== 4'(n_rx) || out_flags !== 2'b00) begin
          errors++;
          $display("FAIL b2b_result_%0d: got q=%h tag=%h f=%b expected q=%h tag=%h f=00",
                   n_rx, out_quot, out_tag, out_flags, vq[n_rx], 4'(n_rx));
        end
      end
      tick();
      if (tx_now) n_tx++;
      if (rx_now) n_rx++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (n_rx != 20) begin errors++; $display("FAIL b2b_all_received: got %0d expected 20", n_rx); end
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_extra: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 32'd50 + 32'(i); in_b = 32'd5; in_tag = 4'(i + 10);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid_%0d: got %b expected 0", k, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready_%0d: got %b expected 1", k, in_ready); end
    end
    run_single("after_reset_9_3", 32'd9, 32'd3, 4'd2, 32'd3, 2'b00, 32'd3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
